// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3, one bit per clock) with optional
// leading-zero blanking; the digit register only updates when a conversion completes.
module bin2bcd_seq #(
  parameter int unsigned W   = 8,
  parameter int unsigned ND  = 3,
  parameter int unsigned LZB = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [W-1:0]    bin,
  output logic            busy,
  output logic            out_valid,
  output logic [4*ND-1:0] bcd,
  output logic            ovf
);

  localparam int unsigned WbW  = 4 * (ND + 1);
  localparam int unsigned CntW = (W > 1) ? $clog2(W) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(W - 1);
  localparam logic [4*ND-1:0] AllOnes = '1;
  // Blanked display of zero: {F..F,0}; raw zeros when blanking is off.
  localparam logic [4*ND-1:0] BcdRst  = (LZB != 0) ? (AllOnes << 4) : '0;

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e          state_q;
  logic [W-1:0]    sr_q;
  logic [WbW-1:0]  wb_q;
  logic [CntW-1:0] cnt_q;
  logic            lost_q;
  logic [4*ND-1:0] bcd_q;
  logic            ovf_q;
  logic            out_valid_q;

  logic [WbW-1:0]  wb_adj;
  logic [WbW-1:0]  wb_shift;
  logic [W-1:0]    sr_shift;
  logic            lost_d;
  logic            ovf_d;
  logic [4*ND-1:0] bcd_d;
  logic            seen;

  always_comb begin
    wb_adj = wb_q;
    for (int i = 0; i < int'(ND) + 1; i++) begin
      if (wb_q[4*i +: 4] >= 4'd5) begin
        wb_adj[4*i +: 4] = wb_q[4*i +: 4] + 4'd3;
      end
    end
    wb_shift = {wb_adj[WbW-2:0], sr_q[W-1]};
    sr_shift = sr_q << 1;
    // A set bit falling off the top of wb means the value outgrew even the guard digit.
    lost_d   = lost_q | wb_adj[WbW-1];
    ovf_d    = lost_d | (wb_shift[WbW-1 -: 4] != 4'd0);

    seen  = 1'b0;
    bcd_d = wb_shift[4*ND-1:0];
    for (int i = int'(ND) - 1; i >= 1; i--) begin
      if (wb_shift[4*i +: 4] != 4'd0) begin
        seen = 1'b1;
      end
      if ((LZB != 0) && !ovf_d && !seen) begin
        bcd_d[4*i +: 4] = 4'hF;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      sr_q        <= '0;
      wb_q        <= '0;
      cnt_q       <= '0;
      lost_q      <= 1'b0;
      bcd_q       <= BcdRst;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (in_valid) begin
            sr_q    <= bin;
            wb_q    <= '0;
            cnt_q   <= '0;
            lost_q  <= 1'b0;
            state_q <= StShift;
          end
        end
        StShift: begin
          sr_q   <= sr_shift;
          wb_q   <= wb_shift;
          lost_q <= lost_d;
          cnt_q  <= cnt_q + 1'b1;
          if (cnt_q == CntLast) begin
            bcd_q       <= bcd_d;
            ovf_q       <= ovf_d;
            out_valid_q <= 1'b1;
            state_q     <= StDone;
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign busy      = (state_q != StIdle);
  assign out_valid = out_valid_q;
  assign bcd       = bcd_q;
  assign ovf       = ovf_q;

endmodule
